// File: rtl/uart_pkg.sv
// Shared UART definitions: parity encodings, receiver state encoding and the
// bit-vote helper used by the oversampling receiver (and the future transmitter).
package uart_pkg;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_ODD  = 1;
   localparam int PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4,
      ST_BREAK  = 3'd5
   } uart_state_e;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle enable every DIV+1 clocks while i_en is
// high; counter held at zero otherwise so the first tick lands on enable.
module uart_baud_tick #(
   parameter int INPUT_CLOCK = 27000000,
   parameter int BAUD_RATE   = 9600,
   parameter int OVERSAMPLE  = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_en,
   output logic o_tick
);

   localparam int TICK_HZ = BAUD_RATE * OVERSAMPLE;
   localparam int DIV     = (INPUT_CLOCK + TICK_HZ / 2) / TICK_HZ - 1;
   localparam int CW      = (DIV > 0) ? $clog2(DIV + 1) : 1;
   localparam logic [CW-1:0] DIV_C = CW'(DIV);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      o_tick = 1'b0;
      if (!i_en) begin
         cnt_d = '0;
      end else if (cnt_q == '0) begin
         o_tick = 1'b1;
         cnt_d  = DIV_C;
      end else if (cnt_q > DIV_C) begin
         cnt_d = DIV_C;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with 3-sample majority vote at mid-bit,
// configurable data/parity/stop bits, parity/framing error flags and break handling.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   ST_IDLE   | line idle, tick divider held; falling edge starts a frame
//   ST_START  | validate start bit at mid-bit; high vote = false start
//   ST_DATA   | shift DATA_BITS voted bits in, LSB first
//   ST_PARITY | compare voted parity bit against data parity
//   ST_STOP   | vote stop bit(s); last one issues the strobe
//   ST_BREAK  | line still low after the frame; wait for it to rise
module uart_rx_os
   import uart_pkg::*;
#(
   parameter int INPUT_CLOCK = 27000000,
   parameter int BAUD_RATE   = 9600,
   parameter int OVERSAMPLE  = 16,
   parameter int DATA_BITS   = 8,
   parameter int PARITY      = 0,
   parameter int STOP_BITS   = 1
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_RX,
   output logic [DATA_BITS-1:0] o_RX_Data,
   output logic                 o_RX_DataValid,
   output logic                 o_ParityErr,
   output logic                 o_FrameErr,
   output logic                 o_Busy
);

   localparam int M  = OVERSAMPLE / 2;
   localparam int OW = $clog2(OVERSAMPLE);

   uart_state_e          state_q, state_d;
   logic                 sync1_q, sync2_q;
   logic [OW-1:0]        os_q, os_d;
   logic [3:0]           bit_q, bit_d;
   logic [1:0]           samp_q, samp_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 perr_q, perr_d, ferr_q, ferr_d;
   logic                 valid_q, valid_d, perr_o_q, perr_o_d, ferr_o_q, ferr_o_d;
   logic                 tick, tick_en, rx_s, vote, decide, bit_end, par_exp;

   assign rx_s    = sync2_q;
   assign tick_en = (state_q == ST_START) || (state_q == ST_DATA) ||
                    (state_q == ST_PARITY) || (state_q == ST_STOP);

   uart_baud_tick #(
      .INPUT_CLOCK (INPUT_CLOCK),
      .BAUD_RATE   (BAUD_RATE),
      .OVERSAMPLE  (OVERSAMPLE)
   ) u_tick (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_en    (tick_en),
      .o_tick  (tick)
   );

   always_comb begin
      state_d  = state_q;
      os_d     = os_q;
      bit_d    = bit_q;
      samp_d   = samp_q;
      shift_d  = shift_q;
      data_d   = data_q;
      perr_d   = perr_q;
      ferr_d   = ferr_q;
      valid_d  = 1'b0;
      perr_o_d = 1'b0;
      ferr_o_d = 1'b0;
      vote     = maj3(samp_q[0], samp_q[1], rx_s);
      decide   = tick && (os_q == OW'(M + 1));
      bit_end  = tick && (os_q == OW'(OVERSAMPLE - 1));
      par_exp  = (^shift_q) ^ (PARITY == PARITY_ODD);

      // Tick index and the two early samples; the third sample is rx_s at decide.
      if (tick && tick_en) begin
         os_d = (os_q >= OW'(OVERSAMPLE - 1)) ? '0 : os_q + 1'b1;
         if (os_q == OW'(M - 1)) samp_d[0] = rx_s;
         if (os_q == OW'(M))     samp_d[1] = rx_s;
      end

      case (state_q)
         ST_IDLE: begin
            os_d  = '0;
            bit_d = '0;
            if (!rx_s) begin
               state_d = ST_START;
               perr_d  = 1'b0;
               ferr_d  = 1'b0;
            end
         end
         ST_START: begin
            if (decide && vote) begin
               state_d = ST_IDLE;
            end else if (bit_end) begin
               state_d = ST_DATA;
               bit_d   = '0;
            end
         end
         ST_DATA: begin
            if (decide) shift_d = {vote, shift_q[DATA_BITS-1:1]};
            if (bit_end) begin
               if (bit_q == 4'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (decide && (vote != par_exp)) perr_d = 1'b1;
            if (bit_end) begin
               state_d = ST_STOP;
               bit_d   = '0;
            end
         end
         ST_STOP: begin
            if (decide) begin
               if (bit_q >= 4'(STOP_BITS - 1)) begin
                  data_d   = shift_q;
                  valid_d  = 1'b1;
                  perr_o_d = perr_q;
                  ferr_o_d = ferr_q | ~vote;
                  state_d  = rx_s ? ST_IDLE : ST_BREAK;
               end else if (!vote) begin
                  ferr_d = 1'b1;
               end
            end
            if (bit_end) bit_d = bit_q + 1'b1;
         end
         ST_BREAK: begin
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= ST_IDLE;
         sync1_q  <= 1'b1;
         sync2_q  <= 1'b1;
         os_q     <= '0;
         bit_q    <= '0;
         samp_q   <= '0;
         shift_q  <= '0;
         data_q   <= '0;
         perr_q   <= 1'b0;
         ferr_q   <= 1'b0;
         valid_q  <= 1'b0;
         perr_o_q <= 1'b0;
         ferr_o_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync1_q  <= i_RX;
         sync2_q  <= sync1_q;
         os_q     <= os_d;
         bit_q    <= bit_d;
         samp_q   <= samp_d;
         shift_q  <= shift_d;
         data_q   <= data_d;
         perr_q   <= perr_d;
         ferr_q   <= ferr_d;
         valid_q  <= valid_d;
         perr_o_q <= perr_o_d;
         ferr_o_q <= ferr_o_d;
      end
   end

   assign o_RX_Data      = data_q;
   assign o_RX_DataValid = valid_q;
   assign o_ParityErr    = perr_o_q;
   assign o_FrameErr     = ferr_o_q;
   assign o_Busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: one 27 MHz 8N1 instance for nominal timing plus three
// fast-divider instances (8N1, 8E1, 7N2) driven from a table and corner sequences.
module tb_uart_rx_os;

   localparam int BIT_S = 2816;  // 16 ticks of 176 clocks
   localparam int BIT_F = 64;    // 16 ticks of 4 clocks
   localparam int FAST  = 614400;
   localparam int NV    = 14;

   typedef struct {
      int         ch;
      logic [11:0] frame;   // bit 0 is first on the line (start bit)
      int         nbits;
      logic [8:0] exp_data;
      logic       exp_pe;
      logic       exp_fe;
   } vec_t;

   logic       clk, rst_n, rst1_n;
   logic [3:0] rx, v, pe, fe, bsy;
   logic [7:0] d0, d1, d2;
   logic [6:0] d3;
   logic [8:0] dat [4];

   int n_cmp = 0, n_bad = 0, cyc = 0;
   int scnt [4] = '{0, 0, 0, 0};
   int leak [4] = '{0, 0, 0, 0};
   int stime[4] = '{0, 0, 0, 0};
   logic [8:0] ldat [4] = '{9'h0, 9'h0, 9'h0, 9'h0};
   logic [8:0] prev [4] = '{9'h0, 9'h0, 9'h0, 9'h0};
   logic       lpe  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
   logic       lfe  [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
   vec_t       vt [NV];

   assign dat[0] = {1'b0, d0};
   assign dat[1] = {1'b0, d1};
   assign dat[2] = {1'b0, d2};
   assign dat[3] = {2'b0, d3};

   uart_rx_os #(.INPUT_CLOCK(27000000), .BAUD_RATE(9600), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_slow (
      .i_clk(clk), .i_rst_n(rst_n), .i_RX(rx[0]), .o_RX_Data(d0),
      .o_RX_DataValid(v[0]), .o_ParityErr(pe[0]), .o_FrameErr(fe[0]), .o_Busy(bsy[0]));

   uart_rx_os #(.INPUT_CLOCK(FAST), .BAUD_RATE(9600), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
      .i_clk(clk), .i_rst_n(rst1_n), .i_RX(rx[1]), .o_RX_Data(d1),
      .o_RX_DataValid(v[1]), .o_ParityErr(pe[1]), .o_FrameErr(fe[1]), .o_Busy(bsy[1]));

   uart_rx_os #(.INPUT_CLOCK(FAST), .BAUD_RATE(9600), .OVERSAMPLE(16),
                .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_RX(rx[2]), .o_RX_Data(d2),
      .o_RX_DataValid(v[2]), .o_ParityErr(pe[2]), .o_FrameErr(fe[2]), .o_Busy(bsy[2]));

   uart_rx_os #(.INPUT_CLOCK(FAST), .BAUD_RATE(9600), .OVERSAMPLE(16),
                .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
      .i_clk(clk), .i_rst_n(rst_n), .i_RX(rx[3]), .o_RX_Data(d3),
      .o_RX_DataValid(v[3]), .o_ParityErr(pe[3]), .o_FrameErr(fe[3]), .o_Busy(bsy[3]));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Strobe monitor: every valid cycle counts, flags outside a strobe are leaks.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (v[i]) begin
            scnt[i]  = scnt[i] + 1;
            prev[i]  = ldat[i];
            ldat[i]  = dat[i];
            lpe[i]   = pe[i];
            lfe[i]   = fe[i];
            stime[i] = cyc;
         end else if (pe[i] || fe[i]) begin
            leak[i] = leak[i] + 1;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bits(input int ch, input logic [11:0] f, input int n, input int bc);
      for (int i = 0; i < n; i++) begin
         rx[ch] = f[i];
         repeat (bc) @(negedge clk);
      end
   endtask

   int c0, t0, lat;
   logic [11:0] fr;

   initial begin
      vt[0]  = '{ch:1, frame:12'({1'b1, 8'hA5, 1'b0}),       nbits:10, exp_data:9'h0A5, exp_pe:1'b0, exp_fe:1'b0};
      vt[1]  = '{ch:1, frame:12'({1'b1, 8'h00, 1'b0}),       nbits:10, exp_data:9'h000, exp_pe:1'b0, exp_fe:1'b0};
      vt[2]  = '{ch:1, frame:12'({1'b1, 8'hFF, 1'b0}),       nbits:10, exp_data:9'h0FF, exp_pe:1'b0, exp_fe:1'b0};
      vt[3]  = '{ch:1, frame:12'({1'b0, 8'h81, 1'b0}),       nbits:10, exp_data:9'h081, exp_pe:1'b0, exp_fe:1'b1};
      vt[4]  = '{ch:2, frame:12'({1'b1, 1'b1, 8'h07, 1'b0}), nbits:11, exp_data:9'h007, exp_pe:1'b0, exp_fe:1'b0};
      vt[5]  = '{ch:2, frame:12'({1'b1, 1'b0, 8'h07, 1'b0}), nbits:11, exp_data:9'h007, exp_pe:1'b1, exp_fe:1'b0};
      vt[6]  = '{ch:2, frame:12'({1'b1, 1'b0, 8'h00, 1'b0}), nbits:11, exp_data:9'h000, exp_pe:1'b0, exp_fe:1'b0};
      vt[7]  = '{ch:2, frame:12'({1'b1, 1'b1, 8'h80, 1'b0}), nbits:11, exp_data:9'h080, exp_pe:1'b0, exp_fe:1'b0};
      vt[8]  = '{ch:2, frame:12'({1'b1, 1'b0, 8'h80, 1'b0}), nbits:11, exp_data:9'h080, exp_pe:1'b1, exp_fe:1'b0};
      vt[9]  = '{ch:2, frame:12'({1'b0, 1'b1, 8'h03, 1'b0}), nbits:11, exp_data:9'h003, exp_pe:1'b1, exp_fe:1'b1};
      vt[10] = '{ch:3, frame:12'({2'b11, 7'h41, 1'b0}),      nbits:10, exp_data:9'h041, exp_pe:1'b0, exp_fe:1'b0};
      vt[11] = '{ch:3, frame:12'({2'b01, 7'h33, 1'b0}),      nbits:10, exp_data:9'h033, exp_pe:1'b0, exp_fe:1'b1};
      vt[12] = '{ch:3, frame:12'({2'b10, 7'h7F, 1'b0}),      nbits:10, exp_data:9'h07F, exp_pe:1'b0, exp_fe:1'b1};
      vt[13] = '{ch:3, frame:12'({2'b11, 7'h00, 1'b0}),      nbits:10, exp_data:9'h000, exp_pe:1'b0, exp_fe:1'b0};

      rx = 4'hF; rst_n = 1'b0; rst1_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy",  32'(bsy), 32'h0);
      check("rst_valid", 32'(v),   32'h0);
      check("rst_flags", 32'({pe, fe}), 32'h0);
      check("rst_data",  32'({d0, d1, d2, d3}), 32'h0);
      rst_n = 1'b1; rst1_n = 1'b1;
      repeat (4) @(negedge clk);

      // Nominal 27 MHz 8N1 frame with strobe latency into the stop bit.
      c0 = scnt[0]; t0 = cyc;
      send_bits(0, 12'({1'b1, 8'hA5, 1'b0}), 10, BIT_S);
      rx[0] = 1'b1;
      repeat (BIT_S) @(negedge clk);
      lat = stime[0] - t0;
      check("slow_cnt",  32'(scnt[0] - c0), 32'd1);
      check("slow_data", 32'(ldat[0]), 32'h0A5);
      check("slow_flags", 32'({lpe[0], lfe[0]}), 32'h0);
      check("slow_busy", 32'(bsy[0]), 32'h0);
      check("slow_lat_in_window", 32'((lat >= 9*BIT_S + 9*176 - 4) && (lat <= 9*BIT_S + 9*176 + 4)), 32'd1);

      for (int k = 0; k < NV; k++) begin
         c0 = scnt[vt[k].ch];
         send_bits(vt[k].ch, vt[k].frame, vt[k].nbits, BIT_F);
         rx[vt[k].ch] = 1'b1;
         repeat (2*BIT_F) @(negedge clk);
         check($sformatf("v%0d_cnt", k),  32'(scnt[vt[k].ch] - c0), 32'd1);
         check($sformatf("v%0d_data", k), 32'(ldat[vt[k].ch]), 32'(vt[k].exp_data));
         check($sformatf("v%0d_pe", k),   32'(lpe[vt[k].ch]), 32'(vt[k].exp_pe));
         check($sformatf("v%0d_fe", k),   32'(lfe[vt[k].ch]), 32'(vt[k].exp_fe));
         check($sformatf("v%0d_busy", k), 32'(bsy[vt[k].ch]), 32'h0);
      end

      // Idle glitch of 4 ticks: false start, no strobe.
      c0 = scnt[1];
      rx[1] = 1'b0;
      repeat (8) @(negedge clk);
      check("glitch_busy_hi", 32'(bsy[1]), 32'h1);
      repeat (8) @(negedge clk);
      rx[1] = 1'b1;
      repeat (BIT_F - 16) @(negedge clk);
      check("glitch_busy_lo", 32'(bsy[1]), 32'h0);
      repeat (BIT_F) @(negedge clk);
      check("glitch_cnt", 32'(scnt[1] - c0), 32'd0);

      // One-tick low glitch at tick M of data bit 2 (a '1'), vote must hold.
      c0 = scnt[1];
      fr = 12'({1'b1, 8'hA5, 1'b0});
      for (int i = 0; i < 10; i++) begin
         if (i == 3) begin
            rx[1] = 1'b1; repeat (32) @(negedge clk);
            rx[1] = 1'b0; repeat (4)  @(negedge clk);
            rx[1] = 1'b1; repeat (28) @(negedge clk);
         end else begin
            rx[1] = fr[i]; repeat (BIT_F) @(negedge clk);
         end
      end
      rx[1] = 1'b1;
      repeat (2*BIT_F) @(negedge clk);
      check("midglitch_cnt",  32'(scnt[1] - c0), 32'd1);
      check("midglitch_data", 32'(ldat[1]), 32'h0A5);
      check("midglitch_flags", 32'({lpe[1], lfe[1]}), 32'h0);

      // Line held low through the stop bit: frame error then break.
      c0 = scnt[1];
      rx[1] = 1'b0;
      repeat (12*BIT_F) @(negedge clk);
      check("brk_cnt",  32'(scnt[1] - c0), 32'd1);
      check("brk_data", 32'(ldat[1]), 32'h000);
      check("brk_fe",   32'(lfe[1]), 32'h1);
      check("brk_pe",   32'(lpe[1]), 32'h0);
      check("brk_busy", 32'(bsy[1]), 32'h1);
      repeat (2*BIT_F) @(negedge clk);
      check("brk_quiet", 32'(scnt[1] - c0), 32'd1);
      rx[1] = 1'b1;
      repeat (BIT_F) @(negedge clk);
      check("brk_idle", 32'(bsy[1]), 32'h0);
      send_bits(1, 12'({1'b1, 8'h55, 1'b0}), 10, BIT_F);
      rx[1] = 1'b1;
      repeat (2*BIT_F) @(negedge clk);
      check("brk_next_cnt",  32'(scnt[1] - c0), 32'd2);
      check("brk_next_data", 32'(ldat[1]), 32'h055);
      check("brk_next_flags", 32'({lpe[1], lfe[1]}), 32'h0);

      // Back-to-back 7N2 frames with no idle gap.
      c0 = scnt[3];
      send_bits(3, 12'({2'b11, 7'h41, 1'b0}), 10, BIT_F);
      send_bits(3, 12'({2'b11, 7'h42, 1'b0}), 10, BIT_F);
      rx[3] = 1'b1;
      repeat (2*BIT_F) @(negedge clk);
      check("b2b_cnt",   32'(scnt[3] - c0), 32'd2);
      check("b2b_first", 32'(prev[3]), 32'h041);
      check("b2b_second", 32'(ldat[3]), 32'h042);
      check("b2b_flags", 32'({lpe[3], lfe[3]}), 32'h0);

      // Reset in the middle of data bit 3, then a clean frame.
      c0 = scnt[1];
      send_bits(1, 12'({1'b1, 8'h3C, 1'b0}), 4, BIT_F);
      rx[1] = 1'b1;
      repeat (BIT_F/2) @(negedge clk);
      rst1_n = 1'b0;
      #1;
      check("mrst_busy", 32'(bsy[1]), 32'h0);
      check("mrst_data", 32'(d1), 32'h0);
      check("mrst_strb", 32'({v[1], pe[1], fe[1]}), 32'h0);
      repeat (4) @(negedge clk);
      rst1_n = 1'b1;
      repeat (2*BIT_F) @(negedge clk);
      check("mrst_nostrobe", 32'(scnt[1] - c0), 32'd0);
      send_bits(1, 12'({1'b1, 8'h3C, 1'b0}), 10, BIT_F);
      rx[1] = 1'b1;
      repeat (2*BIT_F) @(negedge clk);
      check("mrst_cnt",  32'(scnt[1] - c0), 32'd1);
      check("mrst_rx",   32'(ldat[1]), 32'h03C);
      check("mrst_flags", 32'({lpe[1], lfe[1]}), 32'h0);

      for (int i = 0; i < 4; i++)
         check($sformatf("flag_leak_ch%0d", i), 32'(leak[i]), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver; successor to the fixed 8N1 receiver in the serial/LCD path.
Runs on the system clock with a tick enable (no derived clock), majority-votes each bit at mid-bit, and supports configurable data bits, parity and stop bits.
Reports framing and parity errors and handles line breaks.
Feeds byte consumers (LCD command decoder, FIFOs) via a one-cycle valid strobe.

Parameters:
INPUT_CLOCK, 27000000, system clock frequency in Hz
BAUD_RATE, 9600, line bit rate
OVERSAMPLE, 16, ticks per bit; even, >=8
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits expected, 1 or 2

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_RX  in  1  asynchronous serial line, idle high
o_RX_Data  out  DATA_BITS  last received word, LSB = first bit on line
o_RX_DataValid  out  1  one-cycle strobe; o_RX_Data and error flags valid this cycle
o_ParityErr  out  1  qualifies o_RX_DataValid; parity mismatch
o_FrameErr  out  1  qualifies o_RX_DataValid; a stop bit sampled low
o_Busy  out  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset (async assert, sync release internally not required): state IDLE, synchroniser FFs = 1, tick counter = 0, o_RX_Data = 0, all strobes/flags = 0, o_Busy = 0. Reset mid-frame discards the partial word; no strobe is issued.
- Input: 2-FF synchroniser on i_RX; all logic uses the synchronised value (2-cycle latency).
- Tick: divider reloads at DIV = round(INPUT_CLOCK / (BAUD_RATE*OVERSAMPLE)) - 1, giving a one-cycle enable. It is held at 0 in IDLE and restarts on start detection, so phase is aligned to the falling edge.
- Sampling: per bit, the tick index runs 0..OVERSAMPLE-1. Samples are taken at M-1, M, M+1 with M = OVERSAMPLE/2. Bit value = majority of 3. Bit decision happens at tick M+1.
- States:
  IDLE: synced line low -> START, o_Busy = 1.
  START: voted 1 -> false start, back to IDLE, no strobe. Voted 0 -> DATA after bit end.
  DATA: shift voted bit in LSB-first; after DATA_BITS bits -> PARITY if PARITY != 0, else STOP.
  PARITY: expected bit = XOR(data) for even, ~XOR(data) for odd; mismatch latches parity error.
  STOP: each stop bit is voted; any 0 latches frame error. At the decision tick of the last stop bit: o_RX_Data <= word, o_RX_DataValid = 1 for one cycle, o_ParityErr/o_FrameErr driven for that same cycle only. Then -> IDLE if the line is high, else BREAK.
  BREAK: wait until synced line high -> IDLE. Back-to-back frames are accepted starting half a bit after stop mid.
- The strobe issues even on error; consumers must gate on the flags. o_RX_Data holds until the next strobe.
- Latency: strobe occurs M+1 ticks plus 2 cycles into the last stop bit.
- Unused upper counter bits and illegal states recover to IDLE.

Decomposition:
- Shared package uart_pkg: parity encodings (PARITY_NONE/ODD/EVEN) and receiver state enum/localparams.
- The state enum is shared with the future parametrised transmitter.
- Sub-module uart_baud_tick (parameters INPUT_CLOCK, BAUD_RATE, OVERSAMPLE; ports i_clk, i_rst_n, i_en, o_tick). It is reused by the transmitter.

Test Plan:
- 8N1, 9600 baud @27 MHz (DIV = 175): send 0xA5 -> one strobe, o_RX_Data = 0xA5, both flags 0, o_Busy low afterwards.
- PARITY = 2, send 0x07 with parity bit 1 -> flags 0. Resend with parity bit 0 -> o_ParityErr = 1 with strobe, data = 0x07.
- Low glitch of 4 ticks while idle -> no strobe, o_Busy returns to 0 within 1 bit time. A 1-tick glitch at tick M of a data bit -> bit value unaffected.
- Stop bit held low (send 0x00, then line low for 3 bit times) -> strobe with data 0x00, o_FrameErr = 1. No further strobes until the line rises. Next 0x55 is received clean.
- STOP_BITS = 2, DATA_BITS = 7: back-to-back 0x41, 0x42 with no idle gap -> two strobes, data 0x41 then 0x42, no errors. Second stop bit low -> o_FrameErr.
- Assert i_rst_n low mid data bit 3 -> outputs 0 immediately, no strobe. After release, a full 0x3C frame is received correctly.
